seven_segment_scan_driver: RTL and testbench

Parametrised successor to the four-digit ALU display multiplexer. It drives an N-digit multiplexed seven-segment display with active-low segments and anodes. It offers two display modes, hex and true decimal, using a sequential binary-to-BCD converter. It adds leading-zero blanking, per-digit decimal points and overflow indication, and sits between the datapath result bus and the board display pins.

---
 rtl/seg7_pkg.sv | 56 +++++
 rtl/seven_segment_scan_driver_bin2bcd.sv | 53 +++++
 rtl/seven_segment_scan_driver.sv | 188 ++++++++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyphs, hex-to-glyph lookup and scan FSM states
// for the seven-segment scan driver. Segments {g,f,e,d,c,b,a}, 0 = lit.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  function automatic logic [6:0] hex_glyph(
    input logic [3:0] h
  );
    logic [6:0] g;
    g = GLYPH_BLANK;
    unique case (h)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      4'hF: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seven_segment_scan_driver_bin2bcd.sv
// Sequential double-dabble: one shift-add-3 step per clock, DATA_W steps.
// Ports: start (loads bin), bcd (result, held after finish), done (last step now).
module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int BCD_W  = 4 * ((DATA_W + 2) / 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic [BCD_W-1:0]  bcd,
  output logic              done
);

  localparam int SH_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [SH_W-1:0]  sh;
  logic [SH_W-1:0]  adj;
  logic [CNT_W-1:0] cnt;
  logic             run;

  // Add 3 to every BCD nibble >= 5 before the shift.
  always_comb begin
    adj = sh;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (sh[DATA_W+4*i +: 4] >= 4'd5)
        adj[DATA_W+4*i +: 4] =
          sh[DATA_W+4*i +: 4] + 4'd3;
    end
  end

  assign done = run && (cnt == CNT_W'(DATA_W - 1));
  assign bcd  = sh[DATA_W +: BCD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh  <= {{BCD_W{1'b0}}, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sh  <= adj << 1;
      cnt <= cnt + CNT_W'(1);
      if (done)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// N-digit multiplexed 7-seg driver: hex/decimal, blanking, dp, overflow dash.
// Ports: value/load/mode/blank_lz/dp_mask in; busy, seg, dp, anode (active low) out.
module seven_segment_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int HEX_W  = 4 * NUM_DIGITS;
  localparam int BCD_W  = 4 * ((DATA_W + 2) / 3);
  // Extra nibble keeps the overflow shift below full width.
  localparam int VEXT_W =
    ((DATA_W > HEX_W) ? DATA_W : HEX_W) + 4;
  localparam int BEXT_W =
    ((BCD_W > HEX_W) ? BCD_W : HEX_W) + 4;
  localparam int RC_W   = $clog2(REFRESH_DIV);
  localparam int IDX_W  =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t state, state_nx;

  logic                  capture;
  logic                  conv_start;
  logic                  conv_done;
  logic                  commit;
  logic [BCD_W-1:0]      bcd;

  logic                  pend_blank;
  logic [NUM_DIGITS-1:0] pend_dp;

  logic [NUM_DIGITS-1:0][3:0] disp_dig;
  logic                       disp_ovf;
  logic                       disp_blank;
  logic [NUM_DIGITS-1:0]      disp_dp;

  logic [VEXT_W-1:0]          val_ext;
  logic [BEXT_W-1:0]          bcd_ext;
  logic [NUM_DIGITS-1:0][3:0] hex_dig;
  logic [NUM_DIGITS-1:0][3:0] dec_dig;
  logic                       hex_ovf;
  logic                       dec_ovf;

  logic [RC_W-1:0]       rc;
  logic [IDX_W-1:0]      idx;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  nz_seen;
  logic [6:0]            seg_nx;

  assign capture    = load && (state == IDLE);
  assign conv_start = capture && mode;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .BCD_W  (BCD_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (value),
    .bcd   (bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (conv_start) state_nx = CONVERT;
      end
      CONVERT: begin
        if (conv_done) state_nx = COMMIT;
      end
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign val_ext = VEXT_W'(value);
  assign bcd_ext = BEXT_W'(bcd);
  assign hex_ovf = |(val_ext >> HEX_W);
  assign dec_ovf = |(bcd_ext >> HEX_W);

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_dig[i] = val_ext[4*i +: 4];
      dec_dig[i] = bcd_ext[4*i +: 4];
    end
  end

  // Decimal attributes wait here so the old display stays intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_blank <= 1'b0;
      pend_dp    <= '0;
    end else if (conv_start) begin
      pend_blank <= blank_lz;
      pend_dp    <= dp_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_dig   <= '0;
      disp_ovf   <= 1'b0;
      disp_blank <= 1'b0;
      disp_dp    <= '0;
    end else if (capture && !mode) begin
      disp_dig   <= hex_dig;
      disp_ovf   <= hex_ovf;
      disp_blank <= blank_lz;
      disp_dp    <= dp_mask;
    end else if (commit) begin
      disp_dig   <= dec_dig;
      disp_ovf   <= dec_ovf;
      disp_blank <= pend_blank;
      disp_dp    <= pend_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc  <= '0;
      idx <= '0;
    end else if (rc == RC_W'(REFRESH_DIV - 1)) begin
      rc <= '0;
      if (idx == IDX_W'(NUM_DIGITS - 1))
        idx <= '0;
      else
        idx <= idx + IDX_W'(1);
    end else begin
      rc <= rc + RC_W'(1);
    end
  end

  // Blank zeros above the top nonzero digit; digit 0 always shows.
  always_comb begin
    nz_seen   = 1'b0;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_seen      = nz_seen || (disp_dig[i] != 4'h0);
      blank_vec[i] = disp_blank && !nz_seen && (i != 0);
    end
  end

  always_comb begin
    seg_nx = hex_glyph(disp_dig[idx]);
    if (disp_ovf)            seg_nx = GLYPH_DASH;
    else if (blank_vec[idx]) seg_nx = GLYPH_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= GLYPH_BLANK;
      dp    <= 1'b1;
      anode <= '1;
    end else begin
      seg   <= seg_nx;
      dp    <= ~disp_dp[idx];
      anode <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver (4 digits, 16 bits).
// Stimulus queues per-digit expectations; a monitor checks each new digit.
module tb_seven_segment_scan_driver;

  localparam int ND = 4;
  localparam int DW = 16;
  localparam int RD = 4;

  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19;
  localparam logic [6:0] G9 = 7'h10;
  localparam logic [6:0] GA = 7'h08;
  localparam logic [6:0] GB = 7'h03;
  localparam logic [6:0] GF = 7'h0E;
  localparam logic [6:0] GD = 7'h3F;
  localparam logic [6:0] GX = 7'h7F;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] value;
  logic          load;
  logic          mode;
  logic          blank_lz;
  logic [ND-1:0] dp_mask;
  logic          busy;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] anode;

  seven_segment_scan_driver #(
    .NUM_DIGITS  (ND),
    .DATA_W      (DW),
    .REFRESH_DIV (RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .mode     (mode),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .seg      (seg),
    .dp       (dp),
    .anode    (anode)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] sg;
    logic       d;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   hold_chk = 1'b0;

  logic [3:0] prev_an = 4'hF;
  int         run_len = 0;
  bit         run_ok  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (anode === 4'hF) begin
      run_ok  = 1'b0;
      run_len = 0;
      prev_an = anode;
    end else if (anode !== prev_an) begin
      if (run_ok && hold_chk) begin
        checks++;
        if (run_len != RD) begin
          errors++;
          $display("FAIL hold_len got %0d expected %0d",
                   run_len, RD);
        end
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (anode !== e.an || seg !== e.sg
            || dp !== e.d) begin
          errors++;
          $display("FAIL %s got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   e.name, anode, seg, dp, e.an, e.sg, e.d);
        end
      end
      run_len = 1;
      run_ok  = hold_chk;
      prev_an = anode;
    end else begin
      run_len++;
    end
  end

  task automatic check_val(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               name, got, expv);
    end
  endtask

  task automatic push_scan(
    string tag,
    logic [6:0] s0, logic [6:0] s1,
    logic [6:0] s2, logic [6:0] s3,
    logic [3:0] m
  );
    q.push_back('{{tag, "_d0"}, 4'b1110, s0, ~m[0]});
    q.push_back('{{tag, "_d1"}, 4'b1101, s1, ~m[1]});
    q.push_back('{{tag, "_d2"}, 4'b1011, s2, ~m[2]});
    q.push_back('{{tag, "_d3"}, 4'b0111, s3, ~m[3]});
  endtask

  // Returns 1 time unit after the first cycle of a digit-3 hold.
  task automatic wait_scan_start(string tag);
    int n = 0;
    while (anode === 4'b0111 && n < 64) begin
      @(negedge clk); n++;
    end
    while (anode !== 4'b0111 && n < 64) begin
      @(negedge clk); n++;
    end
    if (n >= 64) begin
      check_val({tag, "_scan_timeout"}, n, 0);
    end
    #1;
  endtask

  task automatic drain(string tag);
    int n = 0;
    while (q.size() > 0 && n < 64) begin
      @(negedge clk); n++;
    end
    if (q.size() > 0) begin
      check_val({tag, "_drain_timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_load(
    logic [DW-1:0] v, logic m,
    logic b, logic [ND-1:0] d
  );
    value    = v;
    mode     = m;
    blank_lz = b;
    dp_mask  = d;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    load     = 1'b0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    dp_mask  = '0;
    value    = '0;
    @(negedge clk);
    check_val("rst_seg", int'(seg), int'(GX));
    check_val("rst_dp", int'(dp), 1);
    check_val("rst_anode", int'(anode), 15);
    check_val("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    hold_chk = 1'b1;

    wait_scan_start("reset");
    push_scan("reset", G0, G0, G0, G0, 4'b0000);
    drain("reset");

    do_load(16'h1A3F, 1'b0, 1'b0, 4'b0000);
    n = 0;
    repeat (20) begin
      if (busy !== 1'b0) n++;
      @(negedge clk);
    end
    check_val("hex_busy_cycles", n, 0);
    wait_scan_start("hex");
    push_scan("hex", GF, G3, GA, G1, 4'b0000);
    drain("hex");

    wait_scan_start("hold");
    push_scan("hold", GF, G3, GA, G1, 4'b0000);
    do_load(16'd1234, 1'b1, 1'b0, 4'b0000);
    busy_len(n);
    check_val("busy_len_1234", n, DW + 1);
    drain("hold");
    wait_scan_start("dec1234");
    push_scan("dec1234", G4, G3, G2, G1, 4'b0000);
    drain("dec1234");

    do_load(16'd12345, 1'b1, 1'b1, 4'b0100);
    busy_len(n);
    check_val("busy_len_12345", n, DW + 1);
    wait_scan_start("ovf");
    push_scan("ovf", GD, GD, GD, GD, 4'b0100);
    drain("ovf");

    do_load(16'd42, 1'b1, 1'b1, 4'b0010);
    busy_len(n);
    wait_scan_start("blank42");
    push_scan("blank42", G2, G4, GX, GX, 4'b0010);
    drain("blank42");

    do_load(16'h0000, 1'b0, 1'b1, 4'b0000);
    repeat (3) @(negedge clk);
    wait_scan_start("zero");
    push_scan("zero", G0, GX, GX, GX, 4'b0000);
    drain("zero");

    do_load(16'h00B0, 1'b0, 1'b1, 4'b1001);
    repeat (3) @(negedge clk);
    wait_scan_start("hexb0");
    push_scan("hexb0", G0, GB, GX, GX, 4'b1001);
    drain("hexb0");

    do_load(16'd9, 1'b1, 1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h0007, 1'b0, 1'b1, 4'b1111);
    busy_len(n);
    check_val("busy_len_ignore", n, DW + 1 - 4);
    wait_scan_start("ignore");
    push_scan("ignore", G9, G0, G0, G0, 4'b0000);
    drain("ignore");

    do_load(16'd999, 1'b1, 1'b0, 4'b1111);
    repeat (4) @(negedge clk);
    check_val("busy_mid_convert", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_anode", int'(anode), 15);
    rst = 1'b0;
    repeat (DW + 4) @(negedge clk);
    check_val("abort_idle_busy", int'(busy), 0);
    wait_scan_start("abort");
    push_scan("abort", G0, G0, G0, G0, 4'b0000);
    drain("abort");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
